// File: rtl/minidsp_loader.sv
// minidsp_loader: host-side program loader for the minidsp byte command bus.
// Walks stop / init / settle-wait / push-per-word / start, fetching each word
// from a synchronous program memory, with every bus output registered.
module minidsp_loader #(
  parameter int ADDR_W    = 6,
  parameter int HOLD      = 2,
  parameter int GAP       = 2,
  parameter int INIT_WAIT = 500
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [7:0]        sd0,
  output logic [7:0]        sd1,
  output logic [7:0]        sd2,
  output logic [7:0]        sd3,
  output logic [7:0]        sd4,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent
);

  localparam int CNT_W = $clog2(INIT_WAIT + HOLD + GAP + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] PGAP_LAST = CNT_W'(GAP - 2);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(INIT_WAIT - 1);

  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  localparam logic [7:0] CMD_NOP   = 8'd0;
  localparam logic [7:0] CMD_INIT  = 8'd1;
  localparam logic [7:0] CMD_PUSH  = 8'd2;
  localparam logic [7:0] CMD_START = 8'd3;
  localparam logic [7:0] CMD_STOP  = 8'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_GAP1, S_INIT, S_WAIT, S_FETCH, S_SETUP,
    S_PUSH, S_RELEASE, S_PGAP, S_START, S_FIN, S_ASTOP, S_AGAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sd0_q, sd0_d;
  logic [31:0]       code_q, code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   idx_inc_s;
  logic              abortable_s;

  // abort only acts in the load states, not while already winding down
  assign abortable_s = busy_q && (state_q != S_ASTOP) && (state_q != S_AGAP);

  // Next-state, cycle counter and word bookkeeping.
  // rom_addr moves to the next word on PUSH entry so the synchronous memory
  // has its data ready during FETCH; it never moves past the last word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    idx_d     = idx_q;
    len_d     = len_q;
    words_d   = words_q;
    addr_d    = addr_q;
    idx_inc_s = idx_q + LEN_ONE;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (go && !abort) begin
          state_d = S_STOP;
          idx_d   = LEN_ZERO;
          words_d = LEN_ZERO;
          addr_d  = ADDR_ZERO;
          len_d   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STOP: begin
        if (cnt_q == HOLD_LAST) begin state_d = S_GAP1; cnt_d = CNT_ZERO; end
        else begin state_d = S_STOP; end
      end
      S_GAP1: begin
        if (cnt_q == GAP_LAST) begin state_d = S_INIT; cnt_d = CNT_ZERO; end
        else begin state_d = S_GAP1; end
      end
      S_INIT: begin
        if (cnt_q == HOLD_LAST) begin state_d = S_WAIT; cnt_d = CNT_ZERO; end
        else begin state_d = S_INIT; end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = (len_q != LEN_ZERO) ? S_FETCH : S_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FETCH: begin
        state_d = S_SETUP;
        cnt_d   = CNT_ZERO;
      end
      S_SETUP: begin
        state_d = S_PUSH;
        cnt_d   = CNT_ZERO;
        words_d = words_q + LEN_ONE;
        idx_d   = idx_inc_s;
        if (idx_inc_s < len_q) begin addr_d = idx_inc_s[ADDR_W-1:0]; end
        else begin addr_d = addr_q; end
      end
      S_PUSH: begin
        if (cnt_q == HOLD_LAST) begin state_d = S_RELEASE; cnt_d = CNT_ZERO; end
        else begin state_d = S_PUSH; end
      end
      S_RELEASE: begin
        state_d = S_PGAP;
        cnt_d   = CNT_ZERO;
      end
      S_PGAP: begin
        if (cnt_q == PGAP_LAST) begin
          state_d = (idx_q < len_q) ? S_FETCH : S_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_PGAP;
        end
      end
      S_START: begin
        if (cnt_q == HOLD_LAST) begin state_d = S_FIN; cnt_d = CNT_ZERO; end
        else begin state_d = S_START; end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
      S_ASTOP: begin
        if (cnt_q == HOLD_LAST) begin state_d = S_AGAP; cnt_d = CNT_ZERO; end
        else begin state_d = S_ASTOP; end
      end
      S_AGAP: begin
        if (cnt_q == GAP_LAST) begin state_d = S_IDLE; cnt_d = CNT_ZERO; end
        else begin state_d = S_AGAP; end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    if (abort && abortable_s) begin
      state_d = S_ASTOP;
      cnt_d   = CNT_ZERO;
      idx_d   = idx_q;
      words_d = words_q;
      addr_d  = addr_q;
    end else begin
      state_d = state_d;
    end
  end

  // Bus values for the state being entered, so every output is a flop.
  always_comb begin
    sd0_d  = CMD_NOP;
    code_d = 32'd0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      S_IDLE:            busy_d = 1'b0;
      S_FIN:             begin busy_d = 1'b0; done_d = 1'b1; end
      S_STOP, S_ASTOP:   sd0_d = CMD_STOP;
      S_INIT:            sd0_d = CMD_INIT;
      S_START:           sd0_d = CMD_START;
      S_SETUP:           code_d = rom_data;
      S_PUSH:            begin sd0_d = CMD_PUSH; code_d = code_q; end
      S_RELEASE:         code_d = code_q;
      default:           begin sd0_d = CMD_NOP; code_d = 32'd0; end
    endcase
  end

  // State and output registers with asynchronous clear to IDLE / bus NOP.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= LEN_ZERO;
      len_q   <= LEN_ZERO;
      words_q <= LEN_ZERO;
      addr_q  <= ADDR_ZERO;
      sd0_q   <= CMD_NOP;
      code_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      sd0_q   <= sd0_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign sd0        = sd0_q;
  assign sd1        = code_q[31:24];
  assign sd2        = code_q[23:16];
  assign sd3        = code_q[15:8];
  assign sd4        = code_q[7:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_minidsp_loader.sv
// Bench for minidsp_loader: expected bus traffic is built cycle by cycle from
// the command-sequence rules and compared against the bus on every cycle.
module tb_minidsp_loader;

  localparam int ADDR_W    = 6;
  localparam int HOLD      = 2;
  localparam int GAP       = 2;
  localparam int INIT_WAIT = 500;
  localparam int DEPTH     = 64;

  logic              mclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [7:0]        sd0, sd1, sd2, sd3, sd4;
  logic              busy, done;
  logic [ADDR_W:0]   words_sent;

  logic [31:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;
  logic [41:0] exp_q[$];   // {busy, done, sd0, code}
  int          push_start[$];

  minidsp_loader #(.ADDR_W(ADDR_W), .HOLD(HOLD), .GAP(GAP), .INIT_WAIT(INIT_WAIT)) dut (
    .mclk(mclk), .reset_n(reset_n), .go(go), .abort(abort), .prog_len(prog_len),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sd0(sd0), .sd1(sd1), .sd2(sd2), .sd3(sd3), .sd4(sd4),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 mclk = ~mclk;

  // synchronous program memory: data one cycle after address
  always @(posedge mclk) rom_data <= mem[rom_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int n, input logic [7:0] cmd, input logic [31:0] w,
                     input logic b, input logic d);
    for (int i = 0; i < n; i++) exp_q.push_back({b, d, cmd, w});
  endtask

  // Whole load sequence for n words: one entry per cycle after the go edge.
  task automatic build(input int n);
    exp_q.delete();
    push_start.delete();
    add(HOLD, 8'd4, 32'd0, 1'b1, 1'b0);
    add(GAP, 8'd0, 32'd0, 1'b1, 1'b0);
    add(HOLD, 8'd1, 32'd0, 1'b1, 1'b0);
    add(INIT_WAIT, 8'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      add(1, 8'd0, 32'd0, 1'b1, 1'b0);
      add(1, 8'd0, mem[k], 1'b1, 1'b0);
      push_start.push_back(exp_q.size());
      add(HOLD, 8'd2, mem[k], 1'b1, 1'b0);
      add(1, 8'd0, mem[k], 1'b1, 1'b0);
      add(GAP - 1, 8'd0, 32'd0, 1'b1, 1'b0);
    end
    add(HOLD, 8'd3, 32'd0, 1'b1, 1'b0);
    add(1, 8'd0, 32'd0, 1'b0, 1'b1);
    add(1, 8'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // One go; abort_word>=0 aborts in the first cycle of that word's push,
  // go_busy_idx>=0 pulses go again at that cycle of the busy period.
  task automatic run_seq(input int run_id, input int plen, input int abort_word,
                         input int go_busy_idx);
    int n, exp_words, abort_idx, max_addr;
    bit mono;
    logic [ADDR_W-1:0] prev_addr;
    logic [41:0] obs;
    n = (plen > DEPTH) ? DEPTH : plen;
    build(n);
    abort_idx = -1;
    exp_words = n;
    if (abort_word >= 0) begin
      abort_idx = push_start[abort_word];
      while (exp_q.size() > abort_idx + 1) void'(exp_q.pop_back());
      add(HOLD, 8'd4, 32'd0, 1'b1, 1'b0);
      add(GAP, 8'd0, 32'd0, 1'b1, 1'b0);
      add(1, 8'd0, 32'd0, 1'b0, 1'b0);
      exp_words = abort_word + 1;
    end
    @(negedge mclk);
    go = 1'b1;
    prog_len = (ADDR_W+1)'(plen);
    prev_addr = '0;
    max_addr = 0;
    mono = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge mclk);
      obs = {busy, done, sd0, sd1, sd2, sd3, sd4};
      check($sformatf("run%0d cyc%0d bus", run_id, i), 64'(obs), 64'(exp_q[i]));
      if (int'(rom_addr) < int'(prev_addr)) mono = 1'b0;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      prev_addr = rom_addr;
      go = (i == go_busy_idx);
      abort = (abort_idx >= 0) && (i >= abort_idx) && (i < abort_idx + 3);
    end
    go = 1'b0;
    abort = 1'b0;
    check($sformatf("run%0d words_sent", run_id), 64'(words_sent), 64'(exp_words));
    check($sformatf("run%0d rom_addr_monotonic", run_id), 64'(mono), 64'd1);
    if (abort_word < 0)
      check($sformatf("run%0d rom_addr_max", run_id), 64'(max_addr),
            64'((n > 0) ? n - 1 : 0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h3FFF01A1;
    mem[1] = 32'h00000245;
    mem[2] = 32'h0000000D;
    mem[3] = 32'h3FE00282;
    mem[4] = 32'h000001E4;

    repeat (3) @(negedge mclk);
    check("reset_bus", {sd0, sd1, sd2, sd3, sd4}, 64'd0);
    check("reset_ctrl", {rom_addr, busy, done, words_sent}, 64'd0);
    reset_n = 1'b1;
    @(negedge mclk);
    check("idle_after_reset", {busy, done, sd0}, 64'd0);

    run_seq(1, 5, -1, 100);                  // reference program, go while busy
    run_seq(2, 0, -1, -1);                   // empty program
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_seq(3, DEPTH + 5, -1, -1);           // clamped to full memory
    run_seq(4, 5, 2, -1);                    // abort during third push
    run_seq(5, $urandom_range(1, 20), -1, 300);

    // go and abort together in IDLE: nothing starts
    @(negedge mclk);
    go = 1'b1;
    abort = 1'b1;
    @(negedge mclk);
    go = 1'b0;
    abort = 1'b0;
    check("go_abort_idle_busy", {busy, done, sd0}, 64'd0);
    repeat (3) @(negedge mclk);
    check("go_abort_idle_later", {busy, done, sd0}, 64'd0);

    // asynchronous reset in the middle of the init wait
    @(negedge mclk);
    go = 1'b1;
    prog_len = 7'd3;
    @(negedge mclk);
    go = 1'b0;
    repeat (200) @(negedge mclk);
    check("mid_wait_state", {busy, sd0}, {1'b1, 8'd0});
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_bus", {sd0, sd1, sd2, sd3, sd4}, 64'd0);
    check("async_reset_ctrl", {rom_addr, busy, done, words_sent}, 64'd0);
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    check("idle_after_mid_reset", {busy, done, sd0}, 64'd0);

    run_seq(6, $urandom_range(1, 10), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minidsp_loader.md
Name: minidsp_loader

Overview:
- Host-side initiator for the minidsp byte command bus (sd0 = command, sd1..sd4 = 32-bit code, MSB byte on sd1).
- Reads a program from a synchronous ROM/RAM.
- Emits the full load sequence with the bus timing the DSP requires: stop, init, init-settle wait, one push per instruction word, then start.
- Replaces hand-written stimulus; synthesizable for use on the host side of the board.

Parameters:
- ADDR_W, 6, program memory address width; max program = 2**ADDR_W words.
- HOLD, 2, mclk cycles each non-NOP command is held on sd0 (min 1).
- GAP, 2, NOP cycles after each command before the next one (min 2).
- INIT_WAIT, 500, NOP cycles after init before the first push (min 1).

Ports:
- mclk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  start a load sequence; sampled in IDLE only.
- abort  in  1  cancel the sequence in progress; level, sampled every cycle.
- prog_len  in  ADDR_W+1  number of words to push; captured on the go cycle.
- rom_addr  out  ADDR_W  program memory address.
- rom_data  in  32  program word; valid 1 cycle after rom_addr (synchronous read).
- sd0  out  8  command byte: 0 NOP, 1 init, 2 push, 3 start, 4 stop.
- sd1, sd2, sd3, sd4  out  8 each  code bytes [31:24], [23:16], [15:8], [7:0].
- busy  out  1  high from the cycle after go until the return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- words_sent  out  ADDR_W+1  pushes issued in the current/last sequence.

Behaviour:
- All outputs registered. Reset values: sd0..sd4=0, rom_addr=0, busy=0, done=0, words_sent=0, state IDLE. Reset mid-sequence returns to IDLE immediately with the bus at NOP/0.
- Capture of prog_len: prog_len is clamped to 2**ADDR_W when larger and stored as len.
- State sequence (cycle counts are cycles with the stated sd0 value):
  - IDLE: go=1 moves to STOP; sd0=4 is visible starting the cycle after go.
  - STOP: sd0=4, code=0 for HOLD cycles. Then GAP1.
  - GAP1: sd0=0 for GAP cycles. Then INIT.
  - INIT: sd0=1 for HOLD cycles. Then WAIT.
  - WAIT: sd0=0 for INIT_WAIT cycles. Then FETCH if len>0, else START.
  - FETCH: drive rom_addr=idx (1 cycle).
  - SETUP: sd1..sd4 = rom_data, sd0=0 (1 cycle). Code is always stable one cycle before the command.
  - PUSH: sd0=2 with code held, for HOLD cycles; words_sent increments on PUSH entry.
  - RELEASE: sd0=0 with code still held (1 cycle).
  - PGAP: sd0=0, code=0 for GAP-1 cycles. Then idx+1: if idx+1 < len go to FETCH, else START.
  - START: sd0=3, code=0 for HOLD cycles. Then FIN.
  - FIN: done=1 and busy=0 in the same cycle; return to IDLE.
- Sequence length with defaults and N words: 4+2+500+6N+2 = 508+6N cycles of busy.
- Code bytes are 0 whenever sd0 is 1, 3 or 4.
- idx counter is ADDR_W+1 bits, so len = 2**ADDR_W does not wrap. rom_addr is idx[ADDR_W-1:0].
- go while busy is ignored. go and abort both high in IDLE: abort wins, no sequence starts.
- abort=1 while busy:
  - Next cycle enters ASTOP: sd0=4, code=0 for HOLD cycles. This includes abort during STOP, which restarts the hold count.
  - Then GAP cycles of NOP, then IDLE. busy drops on entering IDLE; done is not pulsed.
  - words_sent is frozen at its value when abort was sampled.
  - abort held high during ASTOP has no further effect.
- A PUSH is never truncated below one cycle by abort: abort sampled in PUSH completes that PUSH cycle, then ASTOP.

Test Plan:
- Reset, then go with prog_len=5 from a ROM holding 3FFF01A1, 00000245, 0000000D, 3FE00282, 000001E4:
  - Bus shows 4(x2), 0(x2), 1(x2), 0(x500), then five push groups carrying those codes in order, then 3(x2).
  - done pulses once at cycle 538; words_sent=5.
- prog_len=0 -> no sd0=2 ever; start follows the init wait directly; busy length 508.
- prog_len=2**ADDR_W+5 (e.g. 69, ADDR_W=6) -> clamped to 64 pushes; rom_addr runs 0..63 without wrap; words_sent=64.
- Code timing check on every push: sd1..sd4 equal the word one cycle before sd0=2 and one cycle after sd0 returns to 0; equal to 0 otherwise.
- abort asserted during the third PUSH:
  - That cycle completes, then sd0=4 for 2 cycles and 0 for 2 cycles.
  - busy falls, no done, words_sent=3.
  - A subsequent go runs a full clean sequence.
- Edge cases:
  - go while busy -> no effect.
  - reset_n low mid-WAIT -> all outputs 0 asynchronously.
  - go+abort together in IDLE -> stays IDLE.
